mandel_iter: RTL and testbench
==============================

# mandel_iter

Per-pixel Mandelbrot escape-time engine, directly downstream of the coordinate generator. It accepts one point c = (x0, y0) through a ready/start handshake and iterates z ← z² + c from z = 0 in signed fixed point, one iteration per clock. It reports the iteration count at escape, or max_iter if the point never escapes, which the colour/pixel stage consumes.

## Interface
Parameters:
- BITS, 16: working width. Format is signed 3.(BITS-3); F = BITS-3 fraction bits.
- ITER_BITS, 8: width of iteration counter and max_iter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request to accept a point; honoured only while ready=1
- x0  in  BITS  signed Re(c), 3.F
- y0  in  BITS-1  signed Im(c), 2.F; sign-extended to BITS internally
- max_iter  in  ITER_BITS  iteration limit, sampled at accept
- ready  out  1  engine idle, can accept
- done  out  1  one-cycle pulse, result valid
- iter  out  ITER_BITS  iteration count of last result; held until next done
- escaped  out  1  1 = point escaped, 0 = limit reached or cycle detected; held

## Operation
- States: IDLE, ITER, DONE. ready = (state==IDLE).
- Accept: start && ready at a rising edge.
  - Latches cx = x0, cy = sext(y0), lim = max_iter.
  - Clears x = y = 0 and n = 0; goes to ITER.
  - Later changes on x0/y0/max_iter have no effect.
- ITER, each cycle:
  - Compute xx = (x·x)>>>F, yy = (y·y)>>>F, xy = (x·y)>>>F at full 2·BITS width.
  - Compute mag = xx + yy.
  - Decisions, in priority order:
    - mag ≥ 4<<F: result iter = n, escaped = 1; go to DONE.
    - n == lim: result iter = lim, escaped = 0; go to DONE.
    - Otherwise: x ← sat(xx − yy + cx), y ← sat(2·xy + cy), n ← n+1.
- sat: clamp to BITS-bit signed range [−4, 4−2^−F]. A clamped value always escapes at the next check.
- DONE: done=1 for exactly this cycle; iter/escaped already valid; next state IDLE.
- start is ignored in ITER and DONE; no queueing.
- lim = 0: the first check (z=0) completes with iter=0, escaped=0.

## Timing
- Reset (async, any state): state=IDLE, ready=1, done=0, iter=0, escaped=0; internal x, y, n, checkpoint cleared.
  - Reset mid-iteration aborts without a done pulse.
- Accept edge at cycle T. The check for n=k happens in cycle T+1+k, and done is high in cycle T+2+k.
  - Decision at n=k gives done latency k+2 cycles.
  - ready returns high in cycle T+3+k; back-to-back throughput is k+3 cycles.
- iter/escaped update on the edge entering DONE and hold until the next DONE.

## Configuration
- MANDEL_PERIOD_CHECK_EN defined: periodicity early-out.
  - A checkpoint (px, py) is cleared to 0 at accept.
  - In ITER, for n > 0 with no escape: if (x,y) == (px,py) exactly, result iter = lim, escaped = 0, go to DONE. This has priority just below the escape test.
  - Otherwise, when n is a power of two, (px,py) ← (x,y).
- Undefined: no checkpoint logic; every non-escaping point runs to n == lim.

## Test plan
- Reset: assert rst mid-run -> immediately ready=1, done=0, iter=0, escaped=0; no done pulse follows.
- BITS=16: c=(x0=16'h2000 (1.0), y0=0), max_iter=50 -> z: 0,1,2; mag=4 at n=2 -> done at T+4, iter=2, escaped=1.
- c=(x0=16'hC000 (−2.0), y0=0), max_iter=50 -> escape at n=1 -> done at T+3, iter=1, escaped=1.
- c=(0,0), max_iter=100:
  - Without macro -> done at T+102, iter=100, escaped=0.
  - With MANDEL_PERIOD_CHECK_EN -> done at T+3, iter=100, escaped=0.
- max_iter=0, c=(1.0,0) -> done at T+2, iter=0, escaped=0.
- Pulse start during ITER and change x0 after accept -> neither affects the result; ready stays 0 until T+3+k.

Source files
------------

// File: rtl/mandel_iter.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c in signed 3.F fixed point, one step per clock.
// Optional periodicity early-out is enabled by defining MANDEL_PERIOD_CHECK_EN.
module mandel_iter #(
  parameter int BITS      = 16,
  parameter int ITER_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BITS-1:0]      x0,
  input  logic [BITS-2:0]      y0,
  input  logic [ITER_BITS-1:0] max_iter,
  output logic                 ready,
  output logic                 done,
  output logic [ITER_BITS-1:0] iter,
  output logic                 escaped
);
  localparam int F = BITS - 3;
  localparam int W = 2 * BITS;
  localparam logic signed [W-1:0] FOUR = W'(4) << F;
  localparam logic signed [W-1:0] MAXV = (W'(1) << (BITS - 1)) - W'(1);
  localparam logic signed [W-1:0] MINV = -(W'(1) << (BITS - 1));

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [BITS-1:0]  cx_q, cx_d, cy_q, cy_d, x_q, x_d, y_q, y_d;
  logic [ITER_BITS-1:0]    n_q, n_d, lim_q, lim_d, iter_q, iter_d;
  logic                    escaped_q, escaped_d, done_q, done_d, ready_q, ready_d;
`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [BITS-1:0]  px_q, px_d, py_q, py_d;
  logic                    n_pow2, cyc_hit;
`endif

  logic signed [W-1:0] xw, yw, cxw, cyw, xx, yy, xy, mag, nx, ny;
  logic                esc;

  function automatic logic signed [BITS-1:0] sat(input logic signed [W-1:0] v);
    if (v > MAXV)      sat = MAXV[BITS-1:0];
    else if (v < MINV) sat = MINV[BITS-1:0];
    else               sat = v[BITS-1:0];
  endfunction

  assign xw  = {{BITS{x_q[BITS-1]}}, x_q};
  assign yw  = {{BITS{y_q[BITS-1]}}, y_q};
  assign cxw = {{BITS{cx_q[BITS-1]}}, cx_q};
  assign cyw = {{BITS{cy_q[BITS-1]}}, cy_q};
  assign xx  = (xw * xw) >>> F;
  assign yy  = (yw * yw) >>> F;
  assign xy  = (xw * yw) >>> F;
  assign mag = xx + yy;
  assign esc = (mag >= FOUR);
  assign nx  = xx - yy + cxw;
  assign ny  = (xy <<< 1) + cyw;

`ifdef MANDEL_PERIOD_CHECK_EN
  assign n_pow2  = (n_q != '0) && ((n_q & (n_q - 1'b1)) == '0);
  assign cyc_hit = (n_q != '0) && (x_q == px_q) && (y_q == py_q);
`endif

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    lim_d     = lim_q;
    iter_d    = iter_q;
    escaped_d = escaped_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
`ifdef MANDEL_PERIOD_CHECK_EN
    px_d      = px_q;
    py_d      = py_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          cx_d    = x0;
          cy_d    = {y0[BITS-2], y0};
          lim_d   = max_iter;
          x_d     = '0;
          y_d     = '0;
          n_d     = '0;
`ifdef MANDEL_PERIOD_CHECK_EN
          px_d    = '0;
          py_d    = '0;
`endif
          ready_d = 1'b0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (esc) begin
          iter_d    = n_q;
          escaped_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
`ifdef MANDEL_PERIOD_CHECK_EN
        end else if (cyc_hit) begin
          iter_d    = lim_q;
          escaped_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
`endif
        end else if (n_q == lim_q) begin
          iter_d    = lim_q;
          escaped_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          x_d = sat(nx);
          y_d = sat(ny);
          n_d = n_q + 1'b1;
`ifdef MANDEL_PERIOD_CHECK_EN
          // Checkpoint holds the pre-step point so later orbits can be compared to it.
          if (n_pow2) begin
            px_d = x_q;
            py_d = y_q;
          end
`endif
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      lim_q     <= '0;
      iter_q    <= '0;
      escaped_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef MANDEL_PERIOD_CHECK_EN
      px_q      <= '0;
      py_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      lim_q     <= lim_d;
      iter_q    <= iter_d;
      escaped_q <= escaped_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
`ifdef MANDEL_PERIOD_CHECK_EN
      px_q      <= px_d;
      py_q      <= py_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign iter    = iter_q;
  assign escaped = escaped_q;
endmodule

// File: tb/tb_mandel_iter.sv
// Self-checking bench for mandel_iter: directed corner cases plus random points
// compared against an integer-arithmetic escape-time model.
module tb_mandel_iter;
  localparam int BITS = 16;
  localparam int ITER_BITS = 8;
  localparam int F = BITS - 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [BITS-1:0]      x0 = '0;
  logic [BITS-2:0]      y0 = '0;
  logic [ITER_BITS-1:0] max_iter = '0;
  logic                 ready, done, escaped;
  logic [ITER_BITS-1:0] iter;

  int checks = 0;
  int errors = 0;

  mandel_iter #(.BITS(BITS), .ITER_BITS(ITER_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .max_iter(max_iter),
    .ready(ready), .done(done), .iter(iter), .escaped(escaped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Escape-time reference: returns result count, escape flag and the n at which it decided.
  function automatic void model(input int cx, input int cy, input int lim,
                                output int r_iter, output bit r_esc, output int r_k);
    int x, y, xx, yy, xy, px, py;
    bit hit;
    x = 0; y = 0; px = 0; py = 0;
    r_iter = lim; r_esc = 0; r_k = lim;
    for (int n = 0; n <= 255; n++) begin
      xx = (x * x) >>> F;
      yy = (y * y) >>> F;
      xy = (x * y) >>> F;
      hit = 0;
`ifdef MANDEL_PERIOD_CHECK_EN
      hit = (n > 0) && (x == px) && (y == py);
`endif
      if (xx + yy >= (4 << F)) begin
        r_iter = n; r_esc = 1; r_k = n; return;
      end
      if (hit || n == lim) begin
        r_iter = lim; r_esc = 0; r_k = n; return;
      end
      if (n > 0 && (n & (n - 1)) == 0) begin
        px = x; py = y;
      end
      x = sat(xx - yy + cx);
      y = sat(2 * xy + cy);
    end
  endfunction

  task automatic run_point(input logic [BITS-1:0] px0, input logic [BITS-2:0] py0,
                           input logic [ITER_BITS-1:0] plim, input bit disturb, input string tag);
    int e_iter, e_k, lat;
    bit e_esc, seen;
    model($signed(px0), $signed(py0), int'(plim), e_iter, e_esc, e_k);
    @(negedge clk);
    check({tag, ".ready_pre"}, int'(ready), 1);
    x0 = px0; y0 = py0; max_iter = plim; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".ready_acc"}, int'(ready), 0);
    lat = 1;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (disturb) begin
        x0 = BITS'($urandom);
        y0 = (BITS-1)'($urandom);
        max_iter = ITER_BITS'($urandom);
        start = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else if (disturb) begin
        check({tag, ".ready_busy"}, int'(ready), 0);
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, int'(seen), 1);
    check({tag, ".latency"}, lat, e_k + 2);
    check({tag, ".iter"}, int'(iter), e_iter);
    check({tag, ".escaped"}, int'(escaped), int'(e_esc));
    @(posedge clk); #1;
    check({tag, ".done_1cyc"}, int'(done), 0);
    check({tag, ".ready_back"}, int'(ready), 1);
    check({tag, ".iter_hold"}, int'(iter), e_iter);
  endtask

  initial begin
    bit saw_done;
    #12;
    check("rst.ready", int'(ready), 1);
    check("rst.done", int'(done), 0);
    check("rst.iter", int'(iter), 0);
    check("rst.escaped", int'(escaped), 0);
    @(negedge clk);
    rst = 1'b0;

    run_point(16'h2000, 15'h0000, 8'd50, 0, "c1p0");
    run_point(16'hC000, 15'h0000, 8'd50, 0, "cm2p0");
    run_point(16'h0000, 15'h0000, 8'd100, 0, "c0");
    run_point(16'h2000, 15'h0000, 8'd0, 0, "lim0");
    run_point(16'h2000, 15'h0000, 8'd50, 1, "dist1");
    run_point(16'hF000, 15'h0800, 8'd60, 1, "dist2");
    run_point(16'h7FFF, 15'h3FFF, 8'd20, 0, "corner");
    run_point(16'hE000, 15'h0000, 8'd40, 0, "cm1");

    for (int i = 0; i < 30; i++)
      run_point(BITS'($urandom), (BITS-1)'($urandom), ITER_BITS'($urandom_range(0, 40)), 0,
                $sformatf("rnd%0d", i));

    // Reset mid-run: a non-escaping point with a long limit, aborted after a few cycles.
    @(negedge clk);
    x0 = 16'h0400; y0 = 15'h0400; max_iter = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.ready", int'(ready), 1);
    check("midrst.done", int'(done), 0);
    check("midrst.iter", int'(iter), 0);
    check("midrst.escaped", int'(escaped), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 250; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("midrst.no_done", int'(saw_done), 0);
    check("midrst.ready_idle", int'(ready), 1);

    run_point(16'hC000, 15'h0000, 8'd50, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
